// File: rtl/riscv_alu_wb_buf.sv
// ---------------------------------------------------------------------------
// riscv_alu_wb_buf
//
// Two-entry writeback skid buffer between the execute-stage ALU and the
// register-file write port. ALU results (value + destination index) are
// accepted through a valid/ready handshake, held in order, and presented to
// the register file through a second valid/ready handshake. A combinational
// bypass lookup lets decode forward results that are still buffered.
//
// The storage is a shift pair: e0 is always the head, e1 the younger entry.
//
// Ports:
//   clk_i        clock, all state updates on the rising edge
//   rst_ni       asynchronous active-low reset
//   flush_i      discard all buffered entries and the same-cycle input
//   alu_valid_i  ALU result valid
//   alu_ready_o  buffer can accept (registered state only)
//   alu_p_i      ALU result value
//   alu_rd_i     destination register index (x0 results are consumed, dropped)
//   wb_valid_o   head entry valid
//   wb_ready_i   register file accepts the head entry
//   wb_rd_o      head destination index (0 when empty)
//   wb_value_o   head result value (0 when empty)
//   byp_rs_i     source index to look up
//   byp_hit_o    a buffered entry targets byp_rs_i
//   byp_value_o  value of the youngest matching entry (0 on miss)
//   count_o      occupancy, 0 to 2
// ---------------------------------------------------------------------------
module riscv_alu_wb_buf #(
   parameter int DEPTH = 2,
   parameter int XLEN  = 32
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            flush_i,
   input  logic            alu_valid_i,
   output logic            alu_ready_o,
   input  logic [XLEN-1:0] alu_p_i,
   input  logic [4:0]      alu_rd_i,
   output logic            wb_valid_o,
   input  logic            wb_ready_i,
   output logic [4:0]      wb_rd_o,
   output logic [XLEN-1:0] wb_value_o,
   input  logic [4:0]      byp_rs_i,
   output logic            byp_hit_o,
   output logic [XLEN-1:0] byp_value_o,
   output logic [1:0]      count_o
);

   localparam logic [1:0] FULL = 2'(DEPTH);

   logic [1:0]      cnt;
   logic [4:0]      e0_rd;
   logic [4:0]      e1_rd;
   logic [XLEN-1:0] e0_val;
   logic [XLEN-1:0] e1_val;
   logic            push;
   logic            pop;
   logic            hit0;
   logic            hit1;

   // Ready depends only on the registered count, so there is no path from
   // wb_ready_i or alu_valid_i back to the ALU.
   assign alu_ready_o = (cnt != FULL);
   assign wb_valid_o  = (cnt != 2'd0);
   assign count_o     = cnt;

   // x0 results complete the handshake but are never stored.
   assign push = alu_valid_i & alu_ready_o & (alu_rd_i != 5'd0) & ~flush_i;
   assign pop  = wb_valid_o & wb_ready_i & ~flush_i;

   // Stale entry contents survive a flush, so every output is qualified by
   // the count rather than trusting the storage to be zero.
   assign wb_rd_o    = wb_valid_o ? e0_rd  : 5'd0;
   assign wb_value_o = wb_valid_o ? e0_val : '0;

   // Bypass: the younger entry e1 wins over e0; x0 never hits.
   always_comb begin
      hit0        = (cnt != 2'd0) && (byp_rs_i != 5'd0) && (e0_rd == byp_rs_i);
      hit1        = (cnt == 2'd2) && (byp_rs_i != 5'd0) && (e1_rd == byp_rs_i);
      byp_hit_o   = hit0 | hit1;
      byp_value_o = '0;
      if (hit1)      byp_value_o = e1_val;
      else if (hit0) byp_value_o = e0_val;
   end

   // NOTE: sequential state is written with non-blocking assignments only, so
   // every branch below reads the pre-edge values of e0/e1/cnt.
   // NOTE: the two entries are tiny and the reset state requires them to read
   // 0, so the storage is reset along with the counter.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt    <= 2'd0;
         e0_rd  <= 5'd0;
         e1_rd  <= 5'd0;
         e0_val <= '0;
         e1_val <= '0;
      end else if (flush_i) begin
         cnt <= 2'd0;
      end else begin
         unique case ({push, pop})
            2'b10: begin
               // Append at the tail: e0 when empty, otherwise e1.
               if (cnt == 2'd0) begin
                  e0_rd  <= alu_rd_i;
                  e0_val <= alu_p_i;
               end else begin
                  e1_rd  <= alu_rd_i;
                  e1_val <= alu_p_i;
               end
               cnt <= cnt + 2'd1;
            end
            2'b01: begin
               // Head leaves; the younger entry shifts into the head slot.
               e0_rd  <= e1_rd;
               e0_val <= e1_val;
               cnt    <= cnt - 2'd1;
            end
            2'b11: begin
               // Simultaneous pop and push: occupancy unchanged, order kept.
               if (cnt == 2'd2) begin
                  e0_rd  <= e1_rd;
                  e0_val <= e1_val;
                  e1_rd  <= alu_rd_i;
                  e1_val <= alu_p_i;
               end else begin
                  e0_rd  <= alu_rd_i;
                  e0_val <= alu_p_i;
               end
            end
            default: ;
         endcase
      end
   end

   // Overflow and underflow are excluded by the handshake; flag any breach.
   a_no_push_when_full : assert property (
      @(posedge clk_i) disable iff (!rst_ni) !(push && (cnt == FULL)));
   a_no_pop_when_empty : assert property (
      @(posedge clk_i) disable iff (!rst_ni) !(pop && (cnt == 2'd0)));
   a_cnt_in_range : assert property (
      @(posedge clk_i) disable iff (!rst_ni) (cnt <= FULL));

endmodule

// File: tb/tb_riscv_alu_wb_buf.sv
// ---------------------------------------------------------------------------
// tb_riscv_alu_wb_buf
//
// Self-checking bench for riscv_alu_wb_buf. A queue of {rd, value} records
// serves as the reference: pushes append, pops remove the front, flush and
// reset empty it, and bypass searches from the back for the youngest match.
// Inputs change on the falling edge; outputs are compared while the clock is
// low, away from the rising edge.
// ---------------------------------------------------------------------------
module tb_riscv_alu_wb_buf;

   localparam int XLEN = 32;

   typedef struct packed {
      logic [4:0]      rd;
      logic [XLEN-1:0] val;
   } ent_t;

   logic            clk_i = 1'b0;
   logic            rst_ni;
   logic            flush_i;
   logic            alu_valid_i;
   logic            alu_ready_o;
   logic [XLEN-1:0] alu_p_i;
   logic [4:0]      alu_rd_i;
   logic            wb_valid_o;
   logic            wb_ready_i;
   logic [4:0]      wb_rd_o;
   logic [XLEN-1:0] wb_value_o;
   logic [4:0]      byp_rs_i;
   logic            byp_hit_o;
   logic [XLEN-1:0] byp_value_o;
   logic [1:0]      count_o;

   int checks = 0;
   int errors = 0;

   ent_t q[$];

   riscv_alu_wb_buf #(.DEPTH(2), .XLEN(XLEN)) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .flush_i     (flush_i),
      .alu_valid_i (alu_valid_i),
      .alu_ready_o (alu_ready_o),
      .alu_p_i     (alu_p_i),
      .alu_rd_i    (alu_rd_i),
      .wb_valid_o  (wb_valid_o),
      .wb_ready_i  (wb_ready_i),
      .wb_rd_o     (wb_rd_o),
      .wb_value_o  (wb_value_o),
      .byp_rs_i    (byp_rs_i),
      .byp_hit_o   (byp_hit_o),
      .byp_value_o (byp_value_o),
      .count_o     (count_o)
   );

   always #5 clk_i = ~clk_i;

   // ---------------- reference model ----------------
   function automatic logic [1:0] m_count();
      return 2'(q.size());
   endfunction

   function automatic logic [4:0] m_head_rd();
      return (q.size() != 0) ? q[0].rd : 5'd0;
   endfunction

   function automatic logic [XLEN-1:0] m_head_val();
      return (q.size() != 0) ? q[0].val : '0;
   endfunction

   function automatic logic m_hit(input logic [4:0] rs);
      for (int i = q.size() - 1; i >= 0; i--)
         if (rs != 5'd0 && q[i].rd == rs) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [XLEN-1:0] m_byp_val(input logic [4:0] rs);
      for (int i = q.size() - 1; i >= 0; i--)
         if (rs != 5'd0 && q[i].rd == rs) return q[i].val;
      return '0;
   endfunction

   // Drive one cycle of stimulus, update the model at the rising edge, and
   // return on the following falling edge with inputs idled.
   task automatic step(input logic v, input logic [4:0] rd,
                       input logic [XLEN-1:0] p, input logic wr,
                       input logic fl);
      bit can_accept;
      bit do_push;
      bit do_pop;
      alu_valid_i = v;
      alu_rd_i    = rd;
      alu_p_i     = p;
      wb_ready_i  = wr;
      flush_i     = fl;
      @(posedge clk_i);
      can_accept = (q.size() < 2);
      if (fl) begin
         q.delete();
      end else begin
         do_pop  = (q.size() != 0) && wr;
         do_push = v && can_accept && (rd != 5'd0);
         if (do_pop) void'(q.pop_front());
         if (do_push) q.push_back(ent_t'{rd: rd, val: p});
      end
      @(negedge clk_i);
      alu_valid_i = 1'b0;
      wb_ready_i  = 1'b0;
      flush_i     = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      // Values held while reset is asserted from time zero.
      byp_rs_i = 5'd5;
      #1;
      checks++; if (count_o !== 2'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count_o); end
      checks++; if (alu_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", alu_ready_o); end
      checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got %b want 0", wb_valid_o); end
      checks++; if (wb_rd_o !== 5'd0 || wb_value_o !== '0) begin errors++; $display("FAIL reset_wb_data got %0d/%h want 0/0", wb_rd_o, wb_value_o); end
      checks++; if (byp_hit_o !== 1'b0 || byp_value_o !== '0) begin errors++; $display("FAIL reset_byp got %b/%h want 0/0", byp_hit_o, byp_value_o); end
      @(negedge clk_i);
      rst_ni = 1'b1;
      // Fill to two entries, then reset asynchronously between edges.
      step(1'b1, 5'd5, 32'h55, 1'b0, 1'b0);
      step(1'b1, 5'd6, 32'h66, 1'b0, 1'b0);
      checks++; if (count_o !== 2'd2) begin errors++; $display("FAIL reset_fill_count got %0d want 2", count_o); end
      byp_rs_i = 5'd6;
      #2 rst_ni = 1'b0;
      q.delete();
      #1;
      checks++; if (count_o !== 2'd0) begin errors++; $display("FAIL midrst_count got %0d want 0", count_o); end
      checks++; if (alu_ready_o !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", alu_ready_o); end
      checks++; if (wb_valid_o !== 1'b0 || wb_rd_o !== 5'd0 || wb_value_o !== '0) begin errors++; $display("FAIL midrst_wb got %b/%0d/%h want 0/0/0", wb_valid_o, wb_rd_o, wb_value_o); end
      checks++; if (byp_hit_o !== 1'b0 || byp_value_o !== '0) begin errors++; $display("FAIL midrst_byp got %b/%h want 0/0", byp_hit_o, byp_value_o); end
      @(negedge clk_i);
      rst_ni = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 5'd0, '0, 1'b1, 1'b0);
         checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL postrst_wb_valid cycle %0d got %b want 0", i, wb_valid_o); end
      end
   endtask

   task automatic test_streaming();
      logic [4:0]      rds[3]  = '{5'd5, 5'd6, 5'd7};
      logic [XLEN-1:0] vals[3] = '{32'h11, 32'h22, 32'h33};
      for (int i = 0; i < 3; i++) begin
         step(1'b1, rds[i], vals[i], 1'b1, 1'b0);
         checks++; if (wb_valid_o !== 1'b1 || wb_rd_o !== rds[i] || wb_value_o !== vals[i]) begin errors++; $display("FAIL stream_head %0d got %b/%0d/%h want 1/%0d/%h", i, wb_valid_o, wb_rd_o, wb_value_o, rds[i], vals[i]); end
         checks++; if (count_o !== 2'd1) begin errors++; $display("FAIL stream_count %0d got %0d want 1", i, count_o); end
      end
      step(1'b0, 5'd0, '0, 1'b1, 1'b0);
      checks++; if (count_o !== 2'd0) begin errors++; $display("FAIL stream_drain got %0d want 0", count_o); end
   endtask

   task automatic test_full_recovery();
      step(1'b1, 5'd1, 32'hA, 1'b0, 1'b0);
      step(1'b1, 5'd2, 32'hB, 1'b0, 1'b0);
      checks++; if (alu_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", alu_ready_o); end
      checks++; if (count_o !== 2'd2) begin errors++; $display("FAIL full_count got %0d want 2", count_o); end
      checks++; if (wb_rd_o !== 5'd1 || wb_value_o !== 32'hA) begin errors++; $display("FAIL full_head got %0d/%h want 1/a", wb_rd_o, wb_value_o); end
      // Offered push while full must be refused.
      step(1'b1, 5'd9, 32'h99, 1'b0, 1'b0);
      checks++; if (count_o !== 2'd2 || wb_rd_o !== 5'd1) begin errors++; $display("FAIL full_refuse got %0d/%0d want 2/1", count_o, wb_rd_o); end
      step(1'b0, 5'd0, '0, 1'b1, 1'b0);
      checks++; if (alu_ready_o !== 1'b1) begin errors++; $display("FAIL recover_ready got %b want 1", alu_ready_o); end
      checks++; if (count_o !== 2'd1 || wb_rd_o !== 5'd2 || wb_value_o !== 32'hB) begin errors++; $display("FAIL recover_head got %0d/%0d/%h want 1/2/b", count_o, wb_rd_o, wb_value_o); end
      step(1'b0, 5'd0, '0, 1'b1, 1'b0);
      checks++; if (count_o !== 2'd0) begin errors++; $display("FAIL recover_drain got %0d want 0", count_o); end
   endtask

   task automatic test_x0_discard();
      step(1'b1, 5'd0, 32'hDEAD, 1'b0, 1'b0);
      checks++; if (count_o !== 2'd0 || wb_valid_o !== 1'b0) begin errors++; $display("FAIL x0_stored got %0d/%b want 0/0", count_o, wb_valid_o); end
      step(1'b1, 5'd3, 32'h1, 1'b0, 1'b0);
      checks++; if (count_o !== 2'd1 || wb_rd_o !== 5'd3 || wb_value_o !== 32'h1) begin errors++; $display("FAIL x0_next got %0d/%0d/%h want 1/3/1", count_o, wb_rd_o, wb_value_o); end
      byp_rs_i = 5'd0;
      #1;
      checks++; if (byp_hit_o !== 1'b0 || byp_value_o !== '0) begin errors++; $display("FAIL x0_byp got %b/%h want 0/0", byp_hit_o, byp_value_o); end
      byp_rs_i = 5'd3;
      #1;
      checks++; if (byp_hit_o !== 1'b1 || byp_value_o !== 32'h1) begin errors++; $display("FAIL x0_byp_rd3 got %b/%h want 1/1", byp_hit_o, byp_value_o); end
      step(1'b0, 5'd0, '0, 1'b1, 1'b0);
      checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL x0_drain got %b want 0", wb_valid_o); end
   endtask

   task automatic test_bypass_priority();
      step(1'b1, 5'd4, 32'h100, 1'b0, 1'b0);
      step(1'b1, 5'd4, 32'h200, 1'b0, 1'b0);
      byp_rs_i = 5'd4;
      #1;
      checks++; if (byp_hit_o !== 1'b1 || byp_value_o !== 32'h200) begin errors++; $display("FAIL byp_youngest got %b/%h want 1/200", byp_hit_o, byp_value_o); end
      byp_rs_i = 5'd9;
      #1;
      checks++; if (byp_hit_o !== 1'b0 || byp_value_o !== '0) begin errors++; $display("FAIL byp_miss got %b/%h want 0/0", byp_hit_o, byp_value_o); end
      // Both entries target rd 4 and drain in order, unmerged.
      step(1'b0, 5'd0, '0, 1'b1, 1'b0);
      checks++; if (count_o !== 2'd1 || wb_rd_o !== 5'd4 || wb_value_o !== 32'h200) begin errors++; $display("FAIL byp_order got %0d/%0d/%h want 1/4/200", count_o, wb_rd_o, wb_value_o); end
      step(1'b0, 5'd0, '0, 1'b1, 1'b0);
   endtask

   task automatic test_flush_collision();
      step(1'b1, 5'd10, 32'hAA, 1'b0, 1'b0);
      step(1'b1, 5'd11, 32'hBB, 1'b0, 1'b0);
      checks++; if (count_o !== 2'd2) begin errors++; $display("FAIL flush_fill got %0d want 2", count_o); end
      step(1'b1, 5'd8, 32'h88, 1'b1, 1'b1);
      checks++; if (count_o !== 2'd0 || wb_valid_o !== 1'b0) begin errors++; $display("FAIL flush_empty got %0d/%b want 0/0", count_o, wb_valid_o); end
      checks++; if (alu_ready_o !== 1'b1) begin errors++; $display("FAIL flush_ready got %b want 1", alu_ready_o); end
      for (int i = 0; i < 2; i++) begin
         step(1'b0, 5'd0, '0, 1'b1, 1'b0);
         checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL flush_no_emit %0d got %b want 0", i, wb_valid_o); end
      end
      // Flush on a single-entry buffer with a push that would otherwise land.
      step(1'b1, 5'd12, 32'hCC, 1'b0, 1'b0);
      step(1'b1, 5'd13, 32'hDD, 1'b1, 1'b1);
      checks++; if (count_o !== 2'd0 || wb_valid_o !== 1'b0) begin errors++; $display("FAIL flush_push_drop got %0d/%b want 0/0", count_o, wb_valid_o); end
   endtask

   task automatic test_random();
      logic [4:0] rs;
      for (int n = 0; n < 500; n++) begin
         rs = 5'($urandom_range(0, 7));
         byp_rs_i = rs;
         #1;
         checks++; if (count_o !== m_count()) begin errors++; $display("FAIL rnd_count n=%0d got %0d want %0d", n, count_o, m_count()); end
         checks++; if (alu_ready_o !== (q.size() < 2)) begin errors++; $display("FAIL rnd_ready n=%0d got %b want %b", n, alu_ready_o, q.size() < 2); end
         checks++; if (wb_valid_o !== (q.size() != 0)) begin errors++; $display("FAIL rnd_wb_valid n=%0d got %b want %b", n, wb_valid_o, q.size() != 0); end
         checks++; if (wb_rd_o !== m_head_rd() || wb_value_o !== m_head_val()) begin errors++; $display("FAIL rnd_head n=%0d got %0d/%h want %0d/%h", n, wb_rd_o, wb_value_o, m_head_rd(), m_head_val()); end
         checks++; if (byp_hit_o !== m_hit(rs) || byp_value_o !== m_byp_val(rs)) begin errors++; $display("FAIL rnd_byp n=%0d rs=%0d got %b/%h want %b/%h", n, rs, byp_hit_o, byp_value_o, m_hit(rs), m_byp_val(rs)); end
         step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
              1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);
      end
   endtask

   initial begin
      rst_ni      = 1'b0;
      flush_i     = 1'b0;
      alu_valid_i = 1'b0;
      alu_p_i     = '0;
      alu_rd_i    = 5'd0;
      wb_ready_i  = 1'b0;
      byp_rs_i    = 5'd0;
      @(negedge clk_i);
      @(negedge clk_i);
      test_reset();
      test_streaming();
      test_full_recovery();
      test_x0_discard();
      test_bypass_priority();
      test_flush_collision();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/riscv_alu_wb_buf.md
# riscv_alu_wb_buf

Two-entry writeback skid buffer directly downstream of the execute-stage ALU. It captures the ALU result together with its destination register index and presents it to the register-file write port through a valid/ready handshake. This decouples ALU issue from register-file write stalls. It also provides a bypass lookup so decode can forward results that are still buffered.

## Interface

Parameters:
- `DEPTH`, 2: buffer entries; fixed at 2, other values unsupported.
- `XLEN`, 32: data width.

Ports:
- `clk_i`  in  1  clock; all state updates on rising edge.
- `rst_ni`  in  1  reset, asynchronous assert, active-low.
- `flush_i`  in  1  synchronous discard of all buffered entries and the same-cycle input.
- `alu_valid_i`  in  1  ALU result valid.
- `alu_ready_o`  out  1  buffer can accept.
- `alu_p_i`  in  XLEN  ALU result.
- `alu_rd_i`  in  5  destination register index.
- `wb_valid_o`  out  1  head entry valid.
- `wb_ready_i`  in  1  register file accepts the head entry.
- `wb_rd_o`  out  5  head destination index.
- `wb_value_o`  out  XLEN  head result.
- `byp_rs_i`  in  5  source index to look up.
- `byp_hit_o`  out  1  a buffered entry targets `byp_rs_i`.
- `byp_value_o`  out  XLEN  value of the youngest matching entry.
- `count_o`  out  2  occupancy, 0 to 2.

## Operation

State:
- Entries `e0` (head) and `e1`, each holding rd and value.
- Occupancy counter `cnt` in 0..2.
- Implementation is either a 2-entry circular FIFO with wrapping read/write pointers or a shift pair. The choice is free; observable behaviour must match this spec.

Handshake:
- `alu_ready_o` = (`cnt` != 2). It is a function of registered state only; there is no combinational path from `wb_ready_i` or `alu_valid_i`.
- Push occurs when `alu_valid_i & alu_ready_o & (alu_rd_i != 0) & !flush_i`.
- An input with `alu_rd_i == 0` is handshaken (consumed) but discarded. It is never stored and never emitted.
- Pop occurs when `wb_valid_o & wb_ready_i & !flush_i`.
- Push and pop in the same cycle: `cnt` is unchanged, the new entry goes to the tail, and order is preserved.
- `wb_valid_o` = (`cnt` != 0). `wb_rd_o` and `wb_value_o` come from the head entry. When `cnt == 0`, both read 0.
- Entries are emitted strictly in acceptance order. No reordering and no merging of same-rd entries.
- Flush: `cnt` goes to 0 the next cycle. Pop and push are both suppressed during the flush cycle.

Bypass (combinational):
- Compare `byp_rs_i` against the rd of every valid entry.
- The youngest match wins: `e1` over `e0` when `cnt == 2`.
- `byp_rs_i == 0` always gives hit 0.
- On no hit, `byp_value_o` = 0.
- The in-flight `alu_p_i` is not included in the lookup.

Arithmetic:
- `cnt` is 2 bits.
- Push at `cnt == 2` and pop at `cnt == 0` are impossible by construction. Assertions must flag them.

## Timing

Reset (asynchronous, while `rst_ni` = 0):
- `cnt` = 0, `alu_ready_o` = 1, `wb_valid_o` = 0.
- `wb_rd_o`, `wb_value_o`, `byp_hit_o`, `byp_value_o`, `count_o` = 0.
- Entry storage is cleared to 0.

Release:
- The first edge after `rst_ni` rises may accept a push.

Latency:
- A push at edge N makes the entry visible on `wb_*` and to bypass after edge N, if the buffer was empty.

Throughput:
- One entry per cycle sustained while `wb_ready_i` is held high.
- When `wb_ready_i` stays low, `alu_ready_o` drops after the second accepted push.
- `alu_ready_o` reasserts the cycle after the first pop.

Reset mid-operation:
- All entries are lost immediately.
- No `wb_valid_o` pulse may occur during or after reset until a new push.

Flush:
- A flush in the same cycle as `wb_ready_i` does not count as a write. The register file must ignore `wb_*` on a flush cycle; this block guarantees `wb_valid_o` = 0 the following cycle.

## Test plan

- **Reset values:** Assert `rst_ni` = 0 mid-stream with `cnt` = 2. Required: outputs 0 and `alu_ready_o` = 1 without waiting for a clock edge; after release, `wb_valid_o` stays 0.
- **Streaming:** Hold `wb_ready_i` = 1 and push rd=5/0x11, rd=6/0x22, rd=7/0x33 on consecutive cycles. Required: `wb_*` shows the same triples one cycle later each, and `cnt` ≤ 1.
- **Full and recovery:** Hold `wb_ready_i` = 0 and push rd=1/0xA, rd=2/0xB. Required: `alu_ready_o` = 0 and `count_o` = 2. Then raise `wb_ready_i` for one cycle. Required: 0xA popped, `alu_ready_o` = 1 the next cycle, head = rd 2/0xB.
- **x0 discard:** Push rd=0/0xDEAD, then rd=3/0x1. Required: only rd 3 is ever emitted, and `byp_rs_i` = 0 gives hit 0.
- **Bypass priority:** Hold `wb_ready_i` = 0 and push rd=4/0x100 then rd=4/0x200. Required: `byp_rs_i` = 4 gives hit 1 with value 0x200; `byp_rs_i` = 9 gives hit 0 with value 0.
- **Flush collision:** With `cnt` = 2, assert `flush_i` together with `alu_valid_i` (rd=8) and `wb_ready_i`. Required: next cycle `cnt` = 0 and `wb_valid_o` = 0, and rd 8 never emitted.
